// File: rtl/fp_divider.sv
// fp_divider: sequential IEEE-754 single divider, radix-2 restoring, one quotient bit per clock.
// Define FPDIV_ROUND_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module fp_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        div_by_zero,
    output logic        overflow,
    output logic        underflow
);
    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;
    state_t st, nxt;
    logic        accept, is_spec, spec, sign, sdbz, ge, hi, carry, inc, ovf, unf;
    logic        za, zb, ma_inf, mb_inf, nan_in;
    logic [31:0] spec_res, sres, norm_res;
    logic [9:0]  e, en0, ef;
    logic [23:0] mb, mant, rnd, diff;
    logic [24:0] r;
    logic [25:0] q;
    logic [4:0]  cnt;
    assign za       = a[30:23] == 8'd0;
    assign zb       = b[30:23] == 8'd0;
    assign ma_inf   = a[30:23] == 8'hFF;
    assign mb_inf   = b[30:23] == 8'hFF;
    assign nan_in   = (ma_inf & |a[22:0]) | (mb_inf & |b[22:0]) | (za & zb) | (ma_inf & mb_inf);
    assign is_spec  = za | zb | ma_inf | mb_inf;
    assign spec_res = nan_in ? 32'h7FC00000 :
                      ma_inf ? {a[31] ^ b[31], 8'hFF, 23'd0} :
                      mb_inf ? {a[31] ^ b[31], 31'd0} :
                      zb     ? {a[31] ^ b[31], 8'hFF, 23'd0} : {a[31] ^ b[31], 31'd0};
    assign accept   = start & (st == IDLE | st == DONE);
    assign busy     = st == DIV | st == NORM;
    assign done     = st == DONE;
    always_comb begin
        nxt = accept ? (is_spec ? NORM : DIV) :
              st == DIV ? (cnt == 5'd25 ? NORM : DIV) :
              st == NORM ? DONE : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) st <= IDLE;
        else st <= nxt;
    assign ge   = r >= {1'b0, mb};
    assign diff = r[23:0] - mb;
    // The quotient of two normalized mantissas lies in (0.5, 2), so the leading mantissa bit is
    // always 1 before rounding; a cleared lead bit afterwards can only mean a rounding carry.
    assign hi   = q[25];
    assign mant = hi ? q[25:2] : q[24:1];
    assign en0  = hi ? e : e - 10'd1;
`ifdef FPDIV_ROUND_EN
    logic guard, sticky;
    assign guard  = hi ? q[1] : q[0];
    assign sticky = (hi & q[0]) | (|r);
    assign inc    = guard & (sticky | mant[0]);
`else
    assign inc    = 1'b0;
`endif
    assign rnd      = mant + {23'd0, inc};
    assign carry    = ~rnd[23];
    assign ef       = en0 + {9'd0, carry};
    assign ovf      = $signed(ef) >= 10'sd255;
    assign unf      = $signed(ef) <= 10'sd0;
    assign norm_res = ovf ? {sign, 8'hFF, 23'd0} : unf ? {sign, 31'd0} : {sign, ef[7:0], rnd[22:0]};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign        <= 1'b0;
            e           <= '0;
            mb          <= '0;
            r           <= '0;
            q           <= '0;
            cnt         <= '0;
            spec        <= 1'b0;
            sres        <= '0;
            sdbz        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (accept) begin
                sign <= a[31] ^ b[31];
                e    <= {2'b00, a[30:23]} - {2'b00, b[30:23]} + 10'd127;
                mb   <= {1'b1, b[22:0]};
                r    <= {2'b01, a[22:0]};
                q    <= '0;
                cnt  <= '0;
                spec <= is_spec;
                sres <= spec_res;
                sdbz <= zb & ~za & ~ma_inf;
            end else if (st == DIV) begin
                r   <= ge ? {diff, 1'b0} : {r[23:0], 1'b0};
                q   <= {q[24:0], ge};
                cnt <= cnt + 5'd1;
            end
            if (st == NORM) begin
                result      <= spec ? sres : norm_res;
                div_by_zero <= spec & sdbz;
                overflow    <= ~spec & ovf;
                underflow   <= ~spec & unf;
            end
        end
    end
endmodule
